// File: rtl/reg_file_mp.sv
// Multi-read-port RV32I register file with async reset, dropped-write flag and a hardware clear sequencer.
// Optional write-first forwarding on the read ports and a0 tap when REGFILE_BYPASS_EN is defined.

module reg_file_mp_rd #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [(1<<AW)-1:0][DW-1:0] mem,
  input  logic [AW-1:0]              addr,
  input  logic                       fwd,
  input  logic [AW-1:0]              wa,
  input  logic [DW-1:0]              wd,
  output logic [DW-1:0]              data
);
  always_comb begin
    data = mem[addr];
    if (fwd && addr == wa) data = wd;
    if (addr == '0) data = '0;
  end
endmodule

module reg_file_mp #(
  parameter int D_WIDTH       = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_RD        = 2,
  parameter int TAP_REG       = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [ADDRESS_WIDTH-1:0]        a3,
  input  logic [D_WIDTH-1:0]              din,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*D_WIDTH-1:0]       rd_data,
  output logic [D_WIDTH-1:0]              a0,
  input  logic                            clr_req,
  output logic                            clr_busy,
  output logic                            clr_done,
  output logic                            wr_drop
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] TAP  = ADDRESS_WIDTH'(TAP_REG);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  logic [DEPTH-1:0][D_WIDTH-1:0] mem;
  state_t                        state;
  logic [ADDRESS_WIDTH-1:0]      idx;
  logic                          wr_ok;
  logic                          fwd;

  assign wr_ok = wr_en && (a3 != '0) && (state != CLEAR);

`ifdef REGFILE_BYPASS_EN
  assign fwd = wr_ok;
`else
  assign fwd = 1'b0;
`endif

  // Entry 0 is never written: the clear walk starts at 1 and writes to x0 are gated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem      <= '0;
      state    <= IDLE;
      idx      <= ADDRESS_WIDTH'(1);
      wr_drop  <= 1'b0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      wr_drop  <= 1'b0;
      clr_done <= 1'b0;
      if (wr_ok) mem[a3] <= din;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            idx      <= ADDRESS_WIDTH'(1);
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          mem[idx] <= '0;
          if (wr_en && a3 != '0) wr_drop <= 1'b1;
          if (idx == LAST) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            idx <= idx + ADDRESS_WIDTH'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      reg_file_mp_rd #(.DW(D_WIDTH), .AW(ADDRESS_WIDTH)) u_rd (
        .mem  (mem),
        .addr (rd_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
        .fwd  (fwd),
        .wa   (a3),
        .wd   (din),
        .data (rd_data[k*D_WIDTH +: D_WIDTH])
      );
    end
  endgenerate

  reg_file_mp_rd #(.DW(D_WIDTH), .AW(ADDRESS_WIDTH)) u_tap (
    .mem  (mem),
    .addr (TAP),
    .fwd  (fwd),
    .wa   (a3),
    .wd   (din),
    .data (a0)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed + random bench for reg_file_mp against a behavioural register-file/clear model.
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        rst, wr_en, clr_req;
  logic [4:0]  a3;
  logic [31:0] din;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [31:0] a0;
  logic        clr_busy, clr_done, wr_drop;

  reg_file_mp dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .a3(a3), .din(din),
    .rd_addr(rd_addr), .rd_data(rd_data), .a0(a0),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: register contents, position of the next entry to clear (0 = not clearing),
  // and the one-cycle done/drop flags visible this cycle.
  logic [31:0] m [32];
  int          clr_pos;
  bit          m_done, m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 0 && clr_pos == 0 && a == wa) return wd;
`endif
    return m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    clr_pos = 0; m_done = 0; m_drop = 0;
  endtask

  task automatic do_reset(input logic [4:0] ra0);
    @(negedge clk);
    wr_en = 0; clr_req = 0; rd_addr = {5'd0, ra0};
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_drop", wr_drop, 0);
    chk("rst_a0", a0, 0);
    chk("rst_rd0", rd_data[31:0], 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive at negedge, check combinational/registered outputs, then advance the model.
  task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input bit cr, input logic [4:0] ra0, input logic [4:0] ra1);
    bit busy;
    @(negedge clk);
    wr_en = we; a3 = wa; din = wd; clr_req = cr; rd_addr = {ra1, ra0};
    #1;
    busy = (clr_pos != 0);
    chk($sformatf("rd0[%0d]", ra0), rd_data[31:0],  exp_rd(ra0, we, wa, wd));
    chk($sformatf("rd1[%0d]", ra1), rd_data[63:32], exp_rd(ra1, we, wa, wd));
    chk("a0",       a0,       exp_rd(5'd10, we, wa, wd));
    chk("clr_busy", clr_busy, busy);
    chk("clr_done", clr_done, m_done);
    chk("wr_drop",  wr_drop,  m_drop);
    m_drop = busy && we && wa != 0;
    if (busy) begin
      m[clr_pos] = 32'h0;
      m_done = (clr_pos == 31);
      clr_pos = (clr_pos == 31) ? 0 : clr_pos + 1;
    end else begin
      if (we && wa != 0) m[wa] = wd;
      if (cr && !m_done) clr_pos = 1;
      m_done = 0;
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; clr_req = 0; a3 = 0; din = 0; rd_addr = 0;
    model_reset();
    do_reset(5'd0);

    // Reset state: every address on both ports reads 0.
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 5'(i), 5'(31 - i));

    // Basic writes, a0 tap, x0 ignored.
    cyc(1, 5, 32'hDEADBEEF, 0, 5, 0);
    cyc(1, 10, 32'h12345678, 0, 5, 10);
    cyc(1, 0, 32'hFFFFFFFF, 0, 5, 10);
    cyc(0, 0, 0, 0, 0, 10);

    // Same-cycle read of the address being written.
    cyc(1, 7, 32'hA5A5A5A5, 0, 5, 7);
    cyc(0, 0, 0, 0, 7, 7);

    // Fill, then full clear; writes after clr_done accepted.
    for (int i = 1; i < 32; i++) cyc(1, 5'(i), 32'(i), 0, 5'(i), 5'(i - 1));
    cyc(0, 0, 0, 1, 3, 31);
    for (int i = 0; i < 33; i++) cyc(0, 0, 0, 1, 5'(i), 5'(31 - i));
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 5'(i), 5'(i));
    cyc(1, 9, 32'hCAFEF00D, 0, 9, 9);
    cyc(0, 0, 0, 0, 9, 9);

    // Write issued during CLEAR is dropped.
    cyc(1, 31, 32'h1, 0, 31, 0);
    cyc(0, 0, 0, 1, 31, 0);
    cyc(0, 0, 0, 0, 31, 0);
    cyc(1, 31, 32'h1, 0, 31, 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 31, 5'(i));

    // Reset mid-clear aborts the sequence.
    cyc(1, 20, 32'h55, 0, 20, 0);
    cyc(0, 0, 0, 1, 20, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 20, 20);
    do_reset(5'd20);
    for (int i = 0; i < 34; i++) cyc(0, 0, 0, 0, 20, 5'(i));

    // Random traffic with occasional clears.
    for (int n = 0; n < 400; n++)
      cyc(($urandom % 3) != 0, 5'($urandom), $urandom, ($urandom % 50) == 0,
          5'($urandom), 5'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
